// File: rtl/perf_pkg.sv
// Shared types for the performance monitor: FSM state encoding and read-select width.
package perf_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    // Index space is NUM_EVENTS event counters plus the cycle counter.
    function automatic int sel_w(input int num_events);
        return (num_events < 1) ? 1 : $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single performance counter with a sticky overflow flag; saturates or wraps at all-ones.
// Latency: updates on the edge after inc/clr; no backpressure (inc sampled every cycle).
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (inc) begin
            if (r_cnt == CNT_MAX) begin
                r_ovf <= 1'b1;
                r_cnt <= (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;

endmodule

// File: rtl/perf_monitor.sv
// Event/cycle performance monitor with halt detection and cycle-limit watchdog.
// Latency: rd_data 1 cycle after rd_sel (reflects that edge's update); no backpressure.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS  = 6,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000,
    parameter int SATURATE    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_EVENTS-1:0]            event_i,
    input  logic                             en,
    input  logic                             hlt,
    input  logic                             clear,
    input  logic [sel_w(NUM_EVENTS)-1:0]     rd_sel,
    output logic [CNT_W-1:0]                 rd_data,
    output logic [NUM_EVENTS:0]              ovf,
    output logic                             done,
    output logic                             timeout
);

    localparam int               SEL_W    = sel_w(NUM_EVENTS);
    localparam int               CYC      = NUM_EVENTS;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [63:0]      LIMIT_M1 = 64'(CYCLE_LIMIT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_run;
    logic              w_tmo_hit;
    logic [NUM_EVENTS:0] w_inc;
    logic [CNT_W-1:0]  w_cnt [NUM_EVENTS+1];
    logic [CNT_W-1:0]  w_sel_cnt;
    logic              w_sel_inc;
    logic [CNT_W-1:0]  w_sel_nxt;
    logic [CNT_W-1:0]  r_rd_data;

    // Cycle counter occupies the top index, after the event counters.
    always_comb begin
        w_inc = '0;
        w_run = (r_state == RUN) && !clear;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            w_inc[k] = w_run && en && event_i[k];
        end
        w_inc[CYC] = w_run;
    end

    assign w_tmo_hit = (64'(w_cnt[CYC]) == LIMIT_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // hlt outranks the watchdog when both land on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = RUN;
        end else if (r_state == RUN) begin
            if (hlt) begin
                w_state_nxt = HALTED;
            end else if (w_tmo_hit) begin
                w_state_nxt = TIMEOUT;
            end
        end
    end

    for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (w_inc[g]),
            .clr   (clear),
            .cnt   (w_cnt[g]),
            .ovf   (ovf[g])
        );
    end

    always_comb begin
        w_sel_cnt = '0;
        w_sel_inc = 1'b0;
        for (int k = 0; k <= NUM_EVENTS; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                w_sel_cnt = w_cnt[k];
                w_sel_inc = w_inc[k];
            end
        end
    end

    // Read path predicts the selected counter's post-edge value so rd_data
    // shows the update made on the same edge it is registered.
    always_comb begin
        w_sel_nxt = w_sel_cnt;
        if (clear) begin
            w_sel_nxt = '0;
        end else if (w_sel_inc) begin
            if (w_sel_cnt == CNT_MAX) begin
                w_sel_nxt = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                w_sel_nxt = w_sel_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_sel_nxt;
        end
    end

    assign rd_data = r_rd_data;
    assign done    = (r_state == HALTED);
    assign timeout = (r_state == TIMEOUT);

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: main instance tracked by a cycle model, plus
// two narrow (CNT_W=4) instances for saturate/wrap boundaries.
module tb_perf_monitor;

    localparam int     NE    = 6;
    localparam int     LIMIT = 50;
    localparam longint MAX32 = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] event_i;
    logic          en;
    logic          hlt;
    logic          clear;
    logic [2:0]    rd_sel;

    logic [31:0]   rd_data;
    logic [NE:0]   ovf;
    logic          done;
    logic          timeout;

    logic [3:0]    rd_data_s;
    logic [NE:0]   ovf_s;
    logic          done_s;
    logic          timeout_s;
    logic [3:0]    rd_data_w;
    logic [NE:0]   ovf_w;
    logic          done_w;
    logic          timeout_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EVENTS(NE), .CNT_W(32), .CYCLE_LIMIT(LIMIT), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .event_i(event_i), .en(en), .hlt(hlt), .clear(clear),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .done(done), .timeout(timeout)
    );

    perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .event_i(event_i), .en(en), .hlt(hlt), .clear(clear),
        .rd_sel(rd_sel), .rd_data(rd_data_s), .ovf(ovf_s), .done(done_s), .timeout(timeout_s)
    );

    perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .event_i(event_i), .en(en), .hlt(hlt), .clear(clear),
        .rd_sel(rd_sel), .rd_data(rd_data_w), .ovf(ovf_w), .done(done_w), .timeout(timeout_w)
    );

    typedef struct {
        logic [31:0] rd;
        logic        done;
        logic        tmo;
        logic [NE:0] ovf;
    } exp_t;

    exp_t        q[$];
    longint      m_cnt [NE+1];
    logic [NE:0] m_ovf;
    int          m_st;   // 0 running, 1 halted, 2 timed out

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k <= NE; k++) m_cnt[k] = 0;
        m_ovf = '0;
        m_st  = 0;
    endtask

    task automatic bump(input int k);
        if (m_cnt[k] == MAX32) m_ovf[k] = 1'b1;
        else m_cnt[k] = m_cnt[k] + 1;
    endtask

    task automatic model_step(input logic r, input logic [NE-1:0] ev, input logic e,
                              input logic h, input logic c, input logic [2:0] s);
        exp_t   x;
        longint cyc_before;
        int     si;
        if (!r || c) begin
            model_zero();
        end else if (m_st == 0) begin
            cyc_before = m_cnt[NE];
            for (int k = 0; k < NE; k++) if (e && ev[k]) bump(k);
            bump(NE);
            if (h) m_st = 1;
            else if (cyc_before == LIMIT - 1) m_st = 2;
        end
        si   = int'(s);
        x.rd = 32'd0;
        if (r && si <= NE) x.rd = 32'(m_cnt[si]);
        x.done = (m_st == 1);
        x.tmo  = (m_st == 2);
        x.ovf  = m_ovf;
        q.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic [NE-1:0] ev, input logic e,
                       input logic h, input logic c, input logic [2:0] s);
        @(negedge clk);
        rst_n   = r;
        event_i = ev;
        en      = e;
        hlt     = h;
        clear   = c;
        rd_sel  = s;
        model_step(r, ev, e, h, c, s);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("sb_rd_data", rd_data, x.rd);
                chk("sb_done", done, x.done);
                chk("sb_timeout", timeout, x.tmo);
                chk("sb_ovf", ovf, x.ovf);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; event_i = '0; en = 1'b0; hlt = 1'b0; clear = 1'b0; rd_sel = '0;
        model_zero();

        // Reset overrides clear, hlt and events.
        cyc(0, 6'h3F, 1, 1, 1, 3'd6);
        cyc(0, 6'h3F, 1, 1, 1, 3'd6);
        sample();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ovf", ovf, 0);

        // 10 cycles of events 0/1, then halt with events still present.
        for (int i = 0; i < 10; i++) cyc(1, 6'h03, 1, 0, 0, 3'd0);
        cyc(1, 6'h03, 1, 1, 0, 3'd0);
        sample();
        chk("halt_cnt0", rd_data, 11);
        chk("halt_done", done, 1);
        cyc(1, 6'h3F, 1, 1, 0, 3'd1); sample(); chk("halt_cnt1", rd_data, 11);
        cyc(1, 6'h3F, 1, 1, 0, 3'd6); sample(); chk("halt_cycles", rd_data, 11);
        cyc(1, 6'h3F, 1, 1, 0, 3'd2); sample(); chk("halt_cnt2", rd_data, 0);
        cyc(1, 6'h3F, 1, 1, 0, 3'd7); sample(); chk("sel_out_of_range", rd_data, 0);

        // Clear in HALTED beats hlt and events.
        cyc(1, 6'h3F, 1, 1, 1, 3'd6);
        sample();
        chk("clr_rd_data", rd_data, 0);
        chk("clr_done", done, 0);
        chk("clr_ovf", ovf, 0);
        cyc(1, 6'h00, 1, 0, 0, 3'd6); sample(); chk("clr_cycle_after", rd_data, 1);

        // Mid-run reset, then event 0 held with en on for 5 of 10 cycles.
        cyc(0, 6'h00, 0, 0, 0, 3'd0);
        for (int i = 1; i <= 10; i++) cyc(1, 6'h01, (i % 2 == 0), (i == 10), 0, 3'd0);
        sample();
        chk("en_cnt0", rd_data, 5);
        chk("en_done", done, 1);
        cyc(1, 6'h00, 0, 0, 0, 3'd6); sample(); chk("en_cycles", rd_data, 10);

        // Watchdog: reset from HALTED, run to the cycle limit.
        cyc(0, 6'h00, 0, 0, 0, 3'd6);
        for (int i = 1; i < LIMIT; i++) cyc(1, 6'h00, 0, 0, 0, 3'd6);
        sample();
        chk("tmo_before_limit", timeout, 0);
        cyc(1, 6'h00, 0, 0, 0, 3'd6);
        sample();
        chk("tmo_fired", timeout, 1);
        chk("tmo_cycles", rd_data, 50);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 6'h3F, 1, 1, 0, 3'd6);
            sample();
            chk("tmo_frozen_cycles", rd_data, 50);
            chk("tmo_ignores_hlt", done, 0);
        end
        cyc(1, 6'h3F, 1, 1, 0, 3'd0); sample(); chk("tmo_frozen_cnt0", rd_data, 0);

        // Clear out of TIMEOUT, then hlt on the limit cycle.
        cyc(1, 6'h00, 0, 0, 1, 3'd6);
        sample();
        chk("clr_tmo_timeout", timeout, 0);
        chk("clr_tmo_rd_data", rd_data, 0);
        for (int i = 1; i < LIMIT; i++) cyc(1, 6'h00, 0, 0, 0, 3'd6);
        cyc(1, 6'h00, 0, 1, 0, 3'd6);
        sample();
        chk("hlt_vs_tmo_done", done, 1);
        chk("hlt_vs_tmo_timeout", timeout, 0);
        chk("hlt_vs_tmo_cycles", rd_data, 50);

        // Narrow counters: 20 pulses on event 2.
        cyc(0, 6'h00, 0, 0, 0, 3'd2);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 6'h04, 1, 0, 0, 3'd2);
            if (i == 15) begin
                sample();
                chk("sat_at_max", rd_data_s, 15);
                chk("sat_at_max_ovf", ovf_s[2], 0);
                chk("wrap_at_max", rd_data_w, 15);
                chk("wrap_at_max_ovf", ovf_w[2], 0);
            end else if (i == 16) begin
                sample();
                chk("sat_hold", rd_data_s, 15);
                chk("sat_ovf_set", ovf_s[2], 1);
                chk("wrap_zero", rd_data_w, 0);
                chk("wrap_ovf_set", ovf_w[2], 1);
            end else if (i == 20) begin
                sample();
                chk("sat_final", rd_data_s, 15);
                chk("sat_ovf_sticky", ovf_s[2], 1);
                chk("wrap_final", rd_data_w, 4);
                chk("wrap_ovf_sticky", ovf_w[2], 1);
                chk("wide_final", rd_data, 20);
            end
        end
        cyc(1, 6'h00, 0, 0, 1, 3'd2);
        sample();
        chk("sat_clr_cnt", rd_data_s, 0);
        chk("sat_clr_ovf", ovf_s, 0);
        chk("wrap_clr_cnt", rd_data_w, 0);
        chk("wrap_clr_ovf", ovf_w, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 6: number of independent event counters.
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter, including the cycle counter.
REQ-003 SHALL have parameter CYCLE_LIMIT, default 100000: cycle count at which the watchdog fires.
REQ-004 SHALL have parameter SATURATE, default 1: 1 = counters saturate at max, 0 = counters wrap.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port event_i, input, NUM_EVENTS: per-event increment strobes (e.g. inst retired, I/D cache req/hit).
REQ-008 SHALL have port en, input, 1: event counting enable; while low, event counters hold.
REQ-009 SHALL have port hlt, input, 1: processor halt indication.
REQ-010 SHALL have port clear, input, 1: single-cycle pulse that zeroes all counters and restarts.
REQ-011 SHALL have port rd_sel, input, SEL_W = clog2(NUM_EVENTS+1): read index; NUM_EVENTS selects the cycle counter.
REQ-012 SHALL have port rd_data, output, CNT_W: registered value of the selected counter.
REQ-013 SHALL have port ovf, output, NUM_EVENTS+1: sticky per-counter overflow flags; MSB belongs to the cycle counter.
REQ-014 SHALL have port done, output, 1: high in HALTED.
REQ-015 SHALL have port timeout, output, 1: high in TIMEOUT.

Function
REQ-016 SHALL implement FSM states RUN, HALTED, TIMEOUT; state after reset is RUN.
REQ-017 In RUN, the cycle counter SHALL increment by 1 every cycle, independent of en.
REQ-018 In RUN with en=1, counter k SHALL increment by 1 in each cycle where event_i[k]=1.
REQ-019 Events present in the cycle where hlt=1 SHALL be counted; the next state SHALL be HALTED.
REQ-020 When the cycle counter equals CYCLE_LIMIT-1 and increments, the next state SHALL be TIMEOUT.
REQ-021 If hlt and the timeout condition occur in the same cycle, hlt SHALL win: next state HALTED, timeout stays 0.
REQ-022 In HALTED and TIMEOUT, all counters SHALL freeze; hlt and event_i SHALL be ignored.
REQ-023 clear=1 in any state SHALL zero all counters and ovf and make the next state RUN; no increment occurs in that cycle.
REQ-024 clear SHALL take priority over hlt, timeout and events arriving in the same cycle.
REQ-025 With SATURATE=1, a counter at 2^CNT_W-1 SHALL hold that value on increment and set its ovf bit.
REQ-026 With SATURATE=0, a counter at 2^CNT_W-1 SHALL wrap to 0 on increment and set its ovf bit.
REQ-027 ovf bits SHALL remain set until clear or reset.
REQ-028 rd_data SHALL have 1-cycle latency: rd_data at cycle t+1 equals the counter value selected by rd_sel at cycle t, including any update made at edge t.
REQ-029 An rd_sel value greater than NUM_EVENTS SHALL return 0.

Reset
REQ-030 With rst_n=0 at a rising edge: state = RUN, all counters = 0, ovf = 0, rd_data = 0, done = 0, timeout = 0.
REQ-031 Reset SHALL override clear, hlt and all events, and SHALL take effect mid-operation in any state.

Structure
REQ-032 Package perf_pkg SHALL hold the state enum (RUN, HALTED, TIMEOUT) and the SEL_W width function.
REQ-033 A sub-module perf_counter (CNT_W, SATURATE; inc, clr in; cnt, ovf out) SHALL be instantiated NUM_EVENTS+1 times.

Verification
REQ-034 Reset, then 10 cycles with event_i=6'b000011 and en=1, then hlt -> counters 0 and 1 = 11, cycle counter = 11, done=1.
REQ-035 CNT_W=4, SATURATE=1, 20 pulses on event 2 -> counter 2 = 15, ovf[2]=1; with SATURATE=0 -> counter 2 = 4, ovf[2]=1.
REQ-036 CYCLE_LIMIT=50, no hlt -> timeout=1 after 50 cycles, cycle counter = 50, frozen thereafter.
REQ-037 hlt coincident with the 50th cycle (CYCLE_LIMIT=50) -> done=1, timeout=0.
REQ-038 Pulse clear in HALTED -> all counters 0, ovf=0, state RUN; rd_sel=NUM_EVENTS reads 1 two cycles later.
REQ-039 en=0 for 5 of 10 cycles with event 0 held high -> counter 0 = 5, cycle counter = 10.
